// File: rtl/ewrapper_link_tx_framer_if.sv
// Emesh-side transaction bus for the eLink transmit framer.
// The source drives one transaction per cycle and watches the two wait lines.
interface ewrapper_link_tx_framer_if;
    logic        emesh_access_outb;
    logic        emesh_write_outb;
    logic [1:0]  emesh_datamode_outb;
    logic [3:0]  emesh_ctrlmode_outb;
    logic [31:0] emesh_dstaddr_outb;
    logic [31:0] emesh_srcaddr_outb;
    logic [31:0] emesh_data_outb;
    logic        emesh_wr_wait_inb;
    logic        emesh_rd_wait_inb;

    modport master (
        output emesh_access_outb, emesh_write_outb, emesh_datamode_outb,
               emesh_ctrlmode_outb, emesh_dstaddr_outb, emesh_srcaddr_outb,
               emesh_data_outb,
        input  emesh_wr_wait_inb, emesh_rd_wait_inb
    );

    modport slave (
        input  emesh_access_outb, emesh_write_outb, emesh_datamode_outb,
               emesh_ctrlmode_outb, emesh_dstaddr_outb, emesh_srcaddr_outb,
               emesh_data_outb,
        output emesh_wr_wait_inb, emesh_rd_wait_inb
    );
endinterface

// File: rtl/ewrapper_link_tx_framer.sv
// eLink transmit framer: buffers emesh transactions and slices each one into
// SLOTS byte times per output word (16-slot full packets, 8-slot burst
// continuations). Optional macro TX_STATS_EN adds packet/stall counters.
module ewrapper_link_tx_framer #(
    parameter int SLOTS      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    txo_lclk,
    input  logic                    reset_n,
    ewrapper_link_tx_framer_if.slave emesh,
    input  logic                    txo_wr_wait,
    input  logic                    txo_rd_wait,
    input  logic                    burst_en,
    output logic [SLOTS*9-1:0]      tx_in,
    output logic                    overflow
`ifdef TX_STATS_EN
    ,
    output logic [31:0]             pkt_count,
    output logic [31:0]             stall_count
`endif
);

    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int FULL_WORDS  = 16 / SLOTS;
    localparam int BURST_WORDS = 8 / SLOTS;
    localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_HIGH = (PTR_W+1)'(FIFO_DEPTH - 2);
    localparam logic [PTR_W:0] FILL_TWO  = (PTR_W+1)'(2);
    localparam logic [15:0]    PKT_FRAME = 16'hFFF8;

    typedef struct packed {
        logic [3:0]  ctrlmode;
        logic [1:0]  datamode;
        logic        write;
        logic [31:0] dstaddr;
        logic [31:0] data;
        logic [31:0] srcaddr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FULL, BURST} state_t;

    entry_t           mem [FIFO_DEPTH];
    entry_t           entry_in, head, second;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill, fill_next;
    logic             push_ok, pop;
    logic             wait_q;
    logic             wr_sync_p0, wr_sync_p1, rd_sync_p0, rd_sync_p1;
    state_t           state, state_next;
    logic [1:0]       wcnt, wcnt_next;
    logic             burst_flag;
    logic             last_word, has_head, has_next;
    logic             head_blocked, next_blocked, hdr_burst, can_burst;
    logic [7:0]       pkt_byte [16];
    logic [SLOTS*8-1:0] word_data;
    logic [SLOTS-1:0] word_frame;
    logic [SLOTS*9-1:0] word_next;
    int               base;
    logic [3:0]       idx;

    // A write head waits on the chip write wait, a read head on the read wait.
    function automatic logic is_blocked(input entry_t e, input logic wr_w, input logic rd_w);
        return e.write ? wr_w : rd_w;
    endfunction

    // Two consecutive double writes with matching ctrlmode and stride 8 chain.
    function automatic logic pair_ok(input entry_t prev, input entry_t nxt);
        return prev.write && nxt.write &&
               (prev.datamode == 2'b11) && (nxt.datamode == 2'b11) &&
               (prev.ctrlmode == nxt.ctrlmode) &&
               (nxt.dstaddr == prev.dstaddr + 32'd8);
    endfunction

    assign entry_in = {emesh.emesh_ctrlmode_outb, emesh.emesh_datamode_outb,
                       emesh.emesh_write_outb, emesh.emesh_dstaddr_outb,
                       emesh.emesh_data_outb, emesh.emesh_srcaddr_outb};
    assign head     = mem[rd_ptr];
    assign second   = mem[rd_ptr + PTR_W'(1)];
    assign push_ok  = emesh.emesh_access_outb && (fill != FILL_FULL);
    assign has_head = (fill != '0);
    assign has_next = (fill >= FILL_TWO);

    assign emesh.emesh_wr_wait_inb = wait_q;
    assign emesh.emesh_rd_wait_inb = wait_q;

    // Fill level after this edge's push and pop.
    always_comb begin
        fill_next = fill;
        case ({push_ok, pop})
            2'b10:   fill_next = fill + 1'b1;
            2'b01:   fill_next = fill - 1'b1;
            default: fill_next = fill;
        endcase
    end

    // Buffer storage is data only and carries no reset.
    always_ff @(posedge txo_lclk) begin
        if (push_ok)
            mem[wr_ptr] <= entry_in;
    end

    // FIFO pointers, fill level, registered wait and sticky overflow.
    always_ff @(posedge txo_lclk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            wait_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fill   <= fill_next;
            wait_q <= (fill_next >= FILL_HIGH);
            if (emesh.emesh_access_outb && (fill == FILL_FULL))
                overflow <= 1'b1;
        end
    end

    // Two-flop synchronizers for the asynchronous chip waits.
    always_ff @(posedge txo_lclk) begin
        if (!reset_n) begin
            wr_sync_p0 <= 1'b0;
            wr_sync_p1 <= 1'b0;
            rd_sync_p0 <= 1'b0;
            rd_sync_p1 <= 1'b0;
        end else begin
            wr_sync_p0 <= txo_wr_wait;
            wr_sync_p1 <= wr_sync_p0;
            rd_sync_p0 <= txo_rd_wait;
            rd_sync_p1 <= rd_sync_p0;
        end
    end

    assign head_blocked = is_blocked(head, wr_sync_p1, rd_sync_p1);
    assign next_blocked = is_blocked(second, wr_sync_p1, rd_sync_p1);
    assign hdr_burst    = burst_en && has_next && pair_ok(head, second);
    // A continuation may only follow a header that announced the burst.
    assign can_burst    = burst_en && pair_ok(head, second) &&
                          ((state == BURST) || burst_flag);
    assign last_word    = ((state == FULL)  && (wcnt == 2'(FULL_WORDS - 1))) ||
                          ((state == BURST) && (wcnt == 2'(BURST_WORDS - 1)));

    // FSM state register, word counter and remembered header burst bit.
    always_ff @(posedge txo_lclk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            burst_flag <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if ((state == FULL) && (wcnt == 2'd0))
                burst_flag <= hdr_burst;
        end
    end

    // Next-state and pop decision; blocking is only looked at on boundaries.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (has_head && !head_blocked) begin
                    state_next = FULL;
                    wcnt_next  = '0;
                end
            end
            FULL, BURST: begin
                if (last_word) begin
                    pop       = 1'b1;
                    wcnt_next = '0;
                    if (has_next && !next_blocked)
                        state_next = can_burst ? BURST : FULL;
                    else
                        state_next = IDLE;
                end else begin
                    wcnt_next = wcnt + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice the 16-slot packet image; a continuation is slots 8-15 of it.
    always_comb begin
        for (int i = 0; i < 16; i++)
            pkt_byte[i] = 8'h00;
        pkt_byte[3] = {head.ctrlmode, head.datamode, head.write, hdr_burst};
        for (int b = 0; b < 4; b++) begin
            pkt_byte[4 + b]  = head.dstaddr[31 - 8*b -: 8];
            pkt_byte[8 + b]  = head.data[31 - 8*b -: 8];
            pkt_byte[12 + b] = head.srcaddr[31 - 8*b -: 8];
        end
        base       = (state == BURST) ? 8 : 0;
        idx        = '0;
        word_data  = '0;
        word_frame = '0;
        for (int s = 0; s < SLOTS; s++) begin
            idx = 4'(base + int'(wcnt) * SLOTS + s);
            word_data[s*8 +: 8] = pkt_byte[idx];
            word_frame[s]       = PKT_FRAME[idx];
        end
        word_next = (state == IDLE) ? '0 : {word_frame, word_data};
    end

    // Output word register toward the SERDES.
    always_ff @(posedge txo_lclk) begin
        if (!reset_n)
            tx_in <= '0;
        else
            tx_in <= word_next;
    end

`ifdef TX_STATS_EN
    // Saturating packet and chip-wait stall counters.
    always_ff @(posedge txo_lclk) begin
        if (!reset_n) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (pkt_count != 32'hFFFF_FFFF))
                pkt_count <= pkt_count + 32'd1;
            if ((state == IDLE) && has_head && head_blocked &&
                (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ewrapper_link_tx_framer.sv
// Directed bench for ewrapper_link_tx_framer (SLOTS=8, FIFO_DEPTH=8).
module tb_ewrapper_link_tx_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        txo_wr_wait, txo_rd_wait, burst_en;
    logic [71:0] tx_in;
    logic        overflow;
`ifdef TX_STATS_EN
    logic [31:0] pkt_count, stall_count;
`endif
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;

    ewrapper_link_tx_framer_if emesh_if ();

    ewrapper_link_tx_framer #(.SLOTS(8), .FIFO_DEPTH(8)) dut (
        .txo_lclk    (clk),
        .reset_n     (reset_n),
        .emesh       (emesh_if),
        .txo_wr_wait (txo_wr_wait),
        .txo_rd_wait (txo_rd_wait),
        .burst_en    (burst_en),
        .tx_in       (tx_in),
        .overflow    (overflow)
`ifdef TX_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // b0 is slot 0 (sent first), b7 is slot 7.
    function automatic logic [63:0] bytes8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic push(input logic wr, input logic [1:0] dm, input logic [3:0] cm,
                        input logic [31:0] dst, input logic [31:0] dat, input logic [31:0] src);
        emesh_if.emesh_access_outb   = 1'b1;
        emesh_if.emesh_write_outb    = wr;
        emesh_if.emesh_datamode_outb = dm;
        emesh_if.emesh_ctrlmode_outb = cm;
        emesh_if.emesh_dstaddr_outb  = dst;
        emesh_if.emesh_data_outb     = dat;
        emesh_if.emesh_srcaddr_outb  = src;
        tick();
        emesh_if.emesh_access_outb   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        txo_wr_wait = 1'b0;
        txo_rd_wait = 1'b0;
        burst_en = 1'b0;
        emesh_if.emesh_access_outb   = 1'b0;
        emesh_if.emesh_write_outb    = 1'b0;
        emesh_if.emesh_datamode_outb = 2'b00;
        emesh_if.emesh_ctrlmode_outb = 4'h0;
        emesh_if.emesh_dstaddr_outb  = 32'h0;
        emesh_if.emesh_data_outb     = 32'h0;
        emesh_if.emesh_srcaddr_outb  = 32'h0;
        tick();
        tick();
        chk("rst_tx_in", tx_in, 72'h0);
        chk("rst_wr_wait", emesh_if.emesh_wr_wait_inb, 1'b0);
        chk("rst_rd_wait", emesh_if.emesh_rd_wait_inb, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single write: header = {0000,10,1,0} = 0x0A.
        push(1'b1, 2'b10, 4'h0, 32'h8000_0000, 32'h1122_3344, 32'hAABB_CCDD);
        chk("single_n0", tx_in, 72'h0);
        tick();
        chk("single_n1", tx_in, 72'h0);
        tick();
        chk("single_w0", tx_in, {8'hF8, 64'h0000_0080_0A00_0000});
        tick();
        chk("single_w1", tx_in, {8'hFF, 64'hDDCC_BBAA_4433_2211});
        tick();
        chk("single_end", tx_in, 72'h0);
        tick();

        // Burst of three double writes: header = {0000,11,1,1} = 0x0F.
        burst_en = 1'b1;
        push(1'b1, 2'b11, 4'h0, 32'h0000_0100, 32'hA1A2_A3A4, 32'hB1B2_B3B4);
        push(1'b1, 2'b11, 4'h0, 32'h0000_0108, 32'hC1C2_C3C4, 32'hE1E2_E3E4);
        push(1'b1, 2'b11, 4'h0, 32'h0000_0110, 32'h0102_0304, 32'h0506_0708);
        chk("burst_w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h00)});
        tick();
        chk("burst_w1", tx_in, {8'hFF, bytes8(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4)});
        tick();
        chk("burst_c1", tx_in, {8'hFF, bytes8(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hE1, 8'hE2, 8'hE3, 8'hE4)});
        tick();
        chk("burst_c2", tx_in, {8'hFF, bytes8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08)});
        tick();
        chk("burst_end", tx_in, 72'h0);
        tick();

        // Same stimulus without burst framing: three full packets, header 0x0E.
        burst_en = 1'b0;
        push(1'b1, 2'b11, 4'h0, 32'h0000_0100, 32'hA1A2_A3A4, 32'hB1B2_B3B4);
        push(1'b1, 2'b11, 4'h0, 32'h0000_0108, 32'hC1C2_C3C4, 32'hE1E2_E3E4);
        push(1'b1, 2'b11, 4'h0, 32'h0000_0110, 32'h0102_0304, 32'h0506_0708);
        chk("nob_p0w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h01, 8'h00)});
        tick();
        chk("nob_p0w1", tx_in, {8'hFF, bytes8(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4)});
        tick();
        chk("nob_p1w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h01, 8'h08)});
        tick();
        chk("nob_p1w1", tx_in, {8'hFF, bytes8(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hE1, 8'hE2, 8'hE3, 8'hE4)});
        tick();
        chk("nob_p2w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h01, 8'h10)});
        tick();
        chk("nob_p2w1", tx_in, {8'hFF, bytes8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08)});
        tick();
        chk("nob_end", tx_in, 72'h0);
        tick();

        // Read head held by chip read wait; write behind it must stay behind.
        txo_rd_wait = 1'b1;
        tick();
        tick();
        tick();
        push(1'b0, 2'b00, 4'h1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0300);
        push(1'b1, 2'b10, 4'h0, 32'h0000_0400, 32'h5566_7788, 32'h99AA_BBCC);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rdhold_%0d", i), tx_in, 72'h0);
        end
        txo_rd_wait = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (tx_in != 72'h0) begin
                lat = i;
                break;
            end
        end
        chk("rd_release_lat", 72'(lat), 72'd4);
        // Read header = {0001,00,0,0} = 0x10.
        chk("rd_w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00)});
        tick();
        chk("rd_w1", tx_in, {8'hFF, bytes8(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00)});
        tick();
        chk("wr_after_rd_w0", tx_in, {8'hF8, bytes8(8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h04, 8'h00)});
        tick();
        chk("wr_after_rd_w1", tx_in, {8'hFF, bytes8(8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC)});
        tick();
        chk("rd_end", tx_in, 72'h0);
        tick();

        // Fill the buffer behind a chip write wait, then overflow it.
        txo_wr_wait = 1'b1;
        tick();
        tick();
        tick();
        for (int k = 1; k <= 8; k++) begin
            push(1'b1, 2'b10, 4'h0, 32'h0000_1000 + 32'(k), 32'(k), 32'h0);
            chk($sformatf("fill%0d_wr_wait", k), emesh_if.emesh_wr_wait_inb, (k >= 6) ? 1'b1 : 1'b0);
        end
        chk("fill8_rd_wait", emesh_if.emesh_rd_wait_inb, 1'b1);
        chk("fill8_overflow", overflow, 1'b0);
        chk("fill8_tx_in", tx_in, 72'h0);
        push(1'b1, 2'b10, 4'h0, 32'h0000_2000, 32'h9, 32'h0);
        chk("ovf_set", overflow, 1'b1);
        tick();
        chk("ovf_sticky", overflow, 1'b1);
        reset_n = 1'b0;
        txo_wr_wait = 1'b0;
        tick();
        chk("ovf_rst_overflow", overflow, 1'b0);
        chk("ovf_rst_wait", emesh_if.emesh_wr_wait_inb, 1'b0);
        reset_n = 1'b1;
        tick();

        // Reset during word0 truncates the packet and empties the buffer.
        push(1'b1, 2'b10, 4'h0, 32'h8000_0000, 32'h1122_3344, 32'hAABB_CCDD);
        tick();
        tick();
        chk("trunc_w0", tx_in, {8'hF8, 64'h0000_0080_0A00_0000});
        reset_n = 1'b0;
        tick();
        chk("trunc_rst_tx_in", tx_in, 72'h0);
        chk("trunc_rst_wr_wait", emesh_if.emesh_wr_wait_inb, 1'b0);
        chk("trunc_rst_rd_wait", emesh_if.emesh_rd_wait_inb, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("trunc_after_%0d", i), tx_in, 72'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
